// File: rtl/shift_reg_pkg.sv
// Shared constants and types for the 64-entry tapped delay line.
package shift_reg_pkg;

  localparam int DEPTH  = 64;
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int DATA_W = 16;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] addr_t;

endpackage

// File: rtl/shift_reg_tap_mux.sv
// Combinational 64:1 tap selector; reads any stored word with zero latency.
module shift_reg_tap_mux
  import shift_reg_pkg::*;
#(
  parameter int dataWidth = 16
) (
  input  logic [dataWidth-1:0] taps [DEPTH],
  input  addr_t                sel,
  output logic [dataWidth-1:0] dout
);

  assign dout = taps[sel];

endmodule

// File: rtl/shift_reg.sv
// Tapped delay line: newest sample at entry 0, oldest at entry 63, random-access
// read through a combinational tap mux.
module shift_reg
  import shift_reg_pkg::*;
#(
  parameter int dataWidth = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 shift,
  input  logic [dataWidth-1:0] din,
  input  addr_t                address,
  output logic [dataWidth-1:0] dout
);

  logic [dataWidth-1:0] mem [DEPTH];
  logic                 seen_rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        mem[k] <= '0;
      end
    end else if (shift) begin
      mem[0] <= din;
      for (int k = 1; k < DEPTH; k++) begin
        mem[k] <= mem[k-1];
      end
    end
  end

  // Contents are undefined until the first reset, so checks only arm afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      seen_rst <= 1'b1;
    end
  end

  shift_reg_tap_mux #(
    .dataWidth(dataWidth)
  ) u_tap_mux (
    .taps(mem),
    .sel (address),
    .dout(dout)
  );

  a_load_newest: assert property (@(posedge clk)
    (seen_rst && !rst && shift) |=> (mem[0] == $past(din)));

  for (genvar k = 0; k < DEPTH; k++) begin : g_chk
    a_reset_clear: assert property (@(posedge clk)
      rst |=> (mem[k] == '0));
    a_hold_keep: assert property (@(posedge clk)
      (seen_rst && !rst && !shift) |=> (mem[k] == $past(mem[k])));
    if (k > 0) begin : g_move
      a_shift_move: assert property (@(posedge clk)
        (seen_rst && !rst && shift) |=> (mem[k] == $past(mem[k-1])));
    end
  end

endmodule

// File: tb/tb_shift_reg.sv
// Self-checking bench for shift_reg: directed scenarios plus randomized traffic
// checked against a queue-based history model.
module tb_shift_reg;

  localparam int W     = 16;
  localparam int DEPTH = 64;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         shift = 1'b0;
  logic [W-1:0] din = '0;
  logic [5:0]   address = '0;
  logic [W-1:0] dout;

  int checks   = 0;
  int failures = 0;

  // History model: index 0 is the newest sample, always exactly DEPTH long after reset.
  logic [W-1:0] model [$];

  always #5 clk = ~clk;

  shift_reg #(
    .dataWidth(W)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .shift  (shift),
    .din    (din),
    .address(address),
    .dout   (dout)
  );

  task automatic checkOutput(input string tag, input logic [W-1:0] observed,
                             input logic [W-1:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic s, input logic [W-1:0] d);
    rst   = r;
    shift = s;
    din   = d;
    @(posedge clk);
    if (r) begin
      model.delete();
      for (int i = 0; i < DEPTH; i++) model.push_back('0);
    end else if (s) begin
      model.push_front(d);
      void'(model.pop_back());
    end
    #1;
    rst   = 1'b0;
    shift = 1'b0;
  endtask

  task automatic checkTap(input string tag, input int a, input logic [W-1:0] expected);
    address = a[5:0];
    #1;
    checkOutput(tag, dout, expected);
  endtask

  task automatic checkAllTaps(input string tag);
    for (int a = 0; a < DEPTH; a++) begin
      address = a[5:0];
      #1;
      checkOutput($sformatf("%s[%0d]", tag, a), dout, model[a]);
    end
  endtask

  initial begin
    // Reset clears every tap.
    applyStimulus(1'b1, 1'b0, '0);
    for (int a = 0; a < DEPTH; a++) begin
      checkTap($sformatf("reset_zero[%0d]", a), a, 16'h0000);
    end

    // Single shift.
    applyStimulus(1'b0, 1'b1, 16'h0001);
    checkTap("single_tap0", 0, 16'h0001);
    checkTap("single_tap1", 1, 16'h0000);

    // Continuous shift with changing din.
    applyStimulus(1'b1, 1'b0, '0);
    repeat (3) applyStimulus(1'b0, 1'b1, 16'h0001);
    applyStimulus(1'b0, 1'b1, 16'hFFFF);
    checkTap("cont_tap2_a", 2, 16'h0001);
    checkTap("cont_tap0_a", 0, 16'hFFFF);
    repeat (2) applyStimulus(1'b0, 1'b1, 16'h00FF);
    checkTap("cont_tap2_b", 2, 16'hFFFF);
    checkTap("cont_tap0_b", 0, 16'h00FF);
    checkTap("cont_tap4_b", 4, 16'h0001);

    // Hold: din wiggles (including X) but nothing is stored.
    for (int i = 0; i < 10; i++) begin
      if (i == 5) applyStimulus(1'b0, 1'b0, 'x);
      else        applyStimulus(1'b0, 1'b0, W'($urandom));
    end
    checkTap("hold_tap0", 0, 16'h00FF);
    checkTap("hold_tap2", 2, 16'hFFFF);
    checkAllTaps("hold_sweep");

    // Depth boundary: value i at shift i.
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 1'b1, W'(i));
    checkTap("depth_tap63", 63, 16'h0000);
    checkTap("depth_tap0", 0, 16'h003F);
    applyStimulus(1'b0, 1'b1, 16'h0040);
    checkTap("depth_tap63_drop", 63, 16'h0001);
    checkTap("depth_tap0_new", 0, 16'h0040);

    // Reset has priority over a simultaneous shift.
    applyStimulus(1'b1, 1'b1, 16'hABCD);
    checkTap("rst_prio_tap0", 0, 16'h0000);
    checkAllTaps("rst_prio_sweep");

    // First shift after reset fills only entry 0.
    applyStimulus(1'b0, 1'b1, 16'h1234);
    checkTap("post_rst_tap0", 0, 16'h1234);
    checkTap("post_rst_tap1", 1, 16'h0000);
    checkTap("post_rst_tap63", 63, 16'h0000);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 500; i++) begin
      applyStimulus($urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0, W'($urandom));
      address = 6'($urandom_range(0, DEPTH - 1));
      #1;
      checkOutput($sformatf("rand_%0d_tap%0d", i, address), dout, model[address]);
    end
    checkAllTaps("final_sweep");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/shift_reg.md
Name: shift_reg

Overview:
- Parameterised tapped delay line: a 64-entry shift register of dataWidth-bit words.
- On each enabled clock, the newest sample enters at entry 0 and every entry moves one position deeper.
- Any entry can be read through a 6-bit address, giving a random-access window onto the last 64 inputs.
- Used as the sample history buffer for filter/datapath blocks that need delayed taps.

Parameters:
- dataWidth, 16, bit width of each stored word and of din/dout.
- DEPTH, 64, number of entries; fixed at 2**ADDR_W.
- ADDR_W, 6, address width; local parameter derived as $clog2(DEPTH).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- shift  input  1  shift enable; when high at a rising edge, din is shifted in.
- din  input  dataWidth  sample written into entry 0 on a shift.
- address  input  6  tap select, 0 = newest entry, 63 = oldest entry.
- dout  output  dataWidth  contents of entry[address].

Behaviour:
- Storage: array mem[0..63] of dataWidth bits.
- Reset:
  - rst=1 at a rising edge clears all 64 entries to 0, so dout reads 0 for every address after reset.
  - rst has priority over shift in the same cycle.
- Shift:
  - With rst=0 and shift=1 at a rising edge, mem[0] <= din and mem[k] <= mem[k-1] for k=1..63.
  - The old mem[63] is discarded; there is no wrap-around.
- Hold: with rst=0 and shift=0, all entries keep their values.
- Read:
  - dout = mem[address], purely combinational with zero latency from address.
  - dout reflects new register contents immediately after the clock edge; there is no output register.
- Latency: a value presented on din at shift edge N appears at tap k after edge N+k (k shifts total).
  - With address=k, dout equals the din sampled k+1 shift-edges earlier, counting the current contents.
- din is sampled only at shifting edges. An X/undefined din while shift=0 must not corrupt storage.
- All 64 address values are valid; there is no out-of-range case.
- Reset mid-stream clears the whole history. The first shift after reset loads din into mem[0], and entries 1..63 remain 0.
- Before the first reset, contents are undefined; the bench always resets first.

Decomposition:
- Package shift_reg_pkg holds:
  - DEPTH=64 and ADDR_W=6 constants;
  - typedef word_t (logic [dataWidth-1:0], default 16);
  - typedef addr_t (logic [ADDR_W-1:0]).
- Single module; no sub-module required.
- The read mux may optionally be a separate tap_mux sub-module (64:1, dataWidth bits) if reused elsewhere.
- Include assertions in the RTL:
  - after rst, mem all zero;
  - on shift, mem[k] equals the previous mem[k-1];
  - on hold, mem unchanged.

Test Plan:
- Reset: drive rst=1 for one edge, then sweep address 0..63 -> dout=16'h0000 at every address.
- Single shift:
  - Set din=16'h0001 and shift=1 for one edge, address=0 -> dout=16'h0001.
  - Then address=1 -> dout=16'h0000.
- Continuous shift with din changing:
  - Shift din=16'h0001 for 3 edges, then 16'hFFFF for 1 edge, then address=2 -> dout=16'h0001.
  - Address=0 -> dout=16'hFFFF.
  - Then din=16'h00FF for 2 more edges -> address=2 reads 16'hFFFF and address=0 reads 16'h00FF.
- Hold: shift=0, toggle din through random values for 10 edges -> all taps unchanged, including with din=X.
- Depth boundary:
  - Shift in 64 distinct values 0..63 (value i at shift i) -> address=63 reads 16'h0000 and address=0 reads 16'h003F.
  - One more shift of 16'h0040 -> address=63 reads 16'h0001; value 0 is discarded.
- Reset priority: rst=1 and shift=1 in the same cycle with din=16'hABCD -> all entries 0; mem[0] is not 16'hABCD.
